rob_commit: RTL and testbench
=============================

Name: rob_commit

Overview:
- 8-entry reorder buffer for the Tomasulo core. Sits directly downstream of the issue/hazard logic.
- Issue logic allocates entries by index. Functional units write results back over the CDB.
- Results retire in program order to the register file / store path.
- Drives the per-entry busy flags that the issue logic uses for ROB-full structural-hazard detection.

Parameters:
- DATA_W, 32, width of result value
- REG_W, 5, width of architectural destination register number
- ENTRIES, 8, number of ROB entries (fixed at 8; index width 3)

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- start  input  1  core run enable; low = flush and hold idle
- issue_valid  input  1  allocate entry this cycle (issue logic reports no structural hazard)
- issue_idx  input  3  ROB index assigned by issue logic (instruction count mod 8)
- issue_op  input  3  opcode: 0 ADD, 1 SUB, 2 MUL, 3 DIV, 4 LOAD, 5 STORE
- issue_dest  input  REG_W  destination register (don't-care for STORE)
- cdb_valid  input  1  common data bus broadcast valid
- cdb_idx  input  3  ROB tag of broadcast result
- cdb_value  input  DATA_W  broadcast result
- commit_stall  input  1  downstream cannot accept a retirement this cycle
- busy_rb  output  8  bit i = entry i allocated and not yet committed
- head_idx  output  3  oldest entry index
- rob_count  output  4  occupied entries, 0..8
- commit_valid  output  1  one-cycle pulse, retirement this cycle
- commit_idx  output  3  retired entry index
- commit_op  output  3  retired opcode
- commit_dest  output  REG_W  retired destination register
- commit_value  output  DATA_W  retired value
- proto_err  output  1  sticky: illegal issue observed

Behaviour:
- Reset (async, rst_n low): all busy/ready cleared; head=tail=0; rob_count=0; all commit_* outputs 0; proto_err 0.
- Flush (start low, sampled at clk): same state as reset, applied synchronously. Issue and CDB are ignored that cycle. This matches the issue logic restarting its index at 0.
- Per-entry state: busy, ready, op, dest, value. Internal tail pointer is 3 bits, wraps 7->0.
- Allocate (issue_valid & start):
  - If issue_idx==tail and entry not busy: set busy=1, ready=0; capture op/dest; tail+1.
  - Otherwise: no state change and proto_err set (sticky until reset/flush).
- Writeback (cdb_valid & start): if entry cdb_idx is busy, set ready=1 and value=cdb_value. A broadcast to a non-busy entry is ignored silently.
- Same-cycle CDB to the entry being allocated: the allocation wins; ready stays 0.
- Commit: at a clock edge where head is busy & ready & !commit_stall:
  - commit_valid=1; commit_idx/op/dest/value loaded from head.
  - Head entry cleared; head+1 (wraps).
  - Otherwise commit_valid=0; the other commit_* outputs hold their last value.
  - At most one retirement per cycle.
- Latency:
  - CDB at edge N sets ready.
  - Earliest commit_valid is high after edge N+1.
  - busy_rb bit drops after the commit edge.
- Simultaneous commit and allocate are legal on different entries. rob_count = count + alloc - commit.
- Full (rob_count==8): busy_rb==8'hFF; commit frees head. The issue logic may reuse that entry no earlier than the next cycle, because busy_rb is registered.
- Empty: no commit. A CDB to an empty ROB is ignored.
- busy_rb, head_idx and rob_count are registered state outputs, with no combinational path from inputs.

Optional Feature:
- ROB_OPERAND_READ_EN.
- Defined: adds inputs rd_tag0/rd_tag1 (3) and outputs rd_ready0/rd_ready1 (1) and rd_value0/rd_value1 (DATA_W). These are combinational lookups of entry ready/value.
- The lookup includes same-cycle CDB forwarding: if cdb_valid & cdb_idx==rd_tagN & entry busy, then ready=1 and value=cdb_value.
- A non-busy tag returns ready=0, value=0.
- Undefined: these ports are absent. Dispatch obtains operands only from the CDB.

Test Plan:
- Reset, start=1, issue idx 0..2 (ADD dest 3, MUL dest 4, LOAD dest 5) -> busy_rb=8'h07, rob_count=3, head_idx=0, no commit.
- CDB idx1 value 0x55 then idx0 value 0x11 -> commit idx0 (dest 3, 0x11), then next cycle idx1 (dest 4, 0x55). Idx2 is held until its CDB arrives.
- Fill 8 entries, CDB all of them, commit_stall=1 for 3 cycles -> busy_rb=8'hFF, no commit_valid. Release -> 8 consecutive commits idx0..7, then busy_rb=0.
- Wrap: commit idx0, then issue idx0 as the 9th instruction -> accepted, tail wraps, proto_err stays 0. Issue idx3 out of order -> proto_err=1, ROB unchanged.
- CDB to idx5 while idx5 not busy -> ignored; a later allocation of idx5 shows ready=0 and does not commit.
- Mid-run start=0 with 4 entries busy -> next cycle busy_rb=0, head=0, count=0. Async rst_n pulse mid-cycle -> outputs zero immediately.

Source files
------------

// File: rtl/rob_commit.sv
// rtl/rob_commit.sv - 8-entry reorder buffer with in-order single retirement per cycle.
// Optional combinational operand lookup with CDB forwarding when ROB_OPERAND_READ_EN is defined.
module rob_commit #(
   parameter int DATA_W  = 32,
   parameter int REG_W   = 5,
   parameter int ENTRIES = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              issue_valid,
   input  logic [2:0]        issue_idx,
   input  logic [2:0]        issue_op,
   input  logic [REG_W-1:0]  issue_dest,
   input  logic              cdb_valid,
   input  logic [2:0]        cdb_idx,
   input  logic [DATA_W-1:0] cdb_value,
   input  logic              commit_stall,
   output logic [7:0]        busy_rb,
   output logic [2:0]        head_idx,
   output logic [3:0]        rob_count,
   output logic              commit_valid,
   output logic [2:0]        commit_idx,
   output logic [2:0]        commit_op,
   output logic [REG_W-1:0]  commit_dest,
   output logic [DATA_W-1:0] commit_value,
`ifdef ROB_OPERAND_READ_EN
   input  logic [2:0]        rd_tag0,
   input  logic [2:0]        rd_tag1,
   output logic              rd_ready0,
   output logic              rd_ready1,
   output logic [DATA_W-1:0] rd_value0,
   output logic [DATA_W-1:0] rd_value1,
`endif
   output logic              proto_err
);

   logic [ENTRIES-1:0] busy_q, busy_d;
   logic [ENTRIES-1:0] ready_q, ready_d;
   logic [2:0]         op_q    [ENTRIES];
   logic [2:0]         op_d    [ENTRIES];
   logic [REG_W-1:0]   dest_q  [ENTRIES];
   logic [REG_W-1:0]   dest_d  [ENTRIES];
   logic [DATA_W-1:0]  value_q [ENTRIES];
   logic [DATA_W-1:0]  value_d [ENTRIES];
   logic [2:0]         head_q, head_d;
   logic [2:0]         tail_q, tail_d;
   logic [3:0]         count_q, count_d;
   logic               commit_valid_q, commit_valid_d;
   logic [2:0]         commit_idx_q, commit_idx_d;
   logic [2:0]         commit_op_q, commit_op_d;
   logic [REG_W-1:0]   commit_dest_q, commit_dest_d;
   logic [DATA_W-1:0]  commit_value_q, commit_value_d;
   logic               proto_err_q, proto_err_d;
   logic               do_alloc;
   logic               do_commit;

   always_comb begin
      busy_d         = busy_q;
      ready_d        = ready_q;
      op_d           = op_q;
      dest_d         = dest_q;
      value_d        = value_q;
      head_d         = head_q;
      tail_d         = tail_q;
      count_d        = count_q;
      commit_valid_d = 1'b0;
      commit_idx_d   = commit_idx_q;
      commit_op_d    = commit_op_q;
      commit_dest_d  = commit_dest_q;
      commit_value_d = commit_value_q;
      proto_err_d    = proto_err_q;
      do_alloc       = 1'b0;
      do_commit      = 1'b0;

      if (!start) begin
         busy_d         = '0;
         ready_d        = '0;
         head_d         = '0;
         tail_d         = '0;
         count_d        = '0;
         commit_idx_d   = '0;
         commit_op_d    = '0;
         commit_dest_d  = '0;
         commit_value_d = '0;
         proto_err_d    = 1'b0;
      end else begin
         // Retirement decision uses pre-edge state, so a CDB result needs one extra edge to commit.
         do_commit      = busy_q[head_q] & ready_q[head_q] & ~commit_stall;
         commit_valid_d = do_commit;
         if (do_commit) begin
            commit_idx_d   = head_q;
            commit_op_d    = op_q[head_q];
            commit_dest_d  = dest_q[head_q];
            commit_value_d = value_q[head_q];
         end

         if (cdb_valid && busy_q[cdb_idx]) begin
            ready_d[cdb_idx] = 1'b1;
            value_d[cdb_idx] = cdb_value;
         end

         // An allocated slot is never busy beforehand, so a same-cycle CDB to it was already ignored.
         if (issue_valid) begin
            if (issue_idx == tail_q && !busy_q[issue_idx]) begin
               do_alloc           = 1'b1;
               busy_d[issue_idx]  = 1'b1;
               ready_d[issue_idx] = 1'b0;
               op_d[issue_idx]    = issue_op;
               dest_d[issue_idx]  = issue_dest;
               tail_d             = tail_q + 3'd1;
            end else begin
               proto_err_d = 1'b1;
            end
         end

         if (do_commit) begin
            busy_d[head_q]  = 1'b0;
            ready_d[head_q] = 1'b0;
            head_d          = head_q + 3'd1;
         end

         count_d = count_q + {3'b000, do_alloc} - {3'b000, do_commit};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q         <= '0;
         ready_q        <= '0;
         head_q         <= '0;
         tail_q         <= '0;
         count_q        <= '0;
         commit_valid_q <= 1'b0;
         commit_idx_q   <= '0;
         commit_op_q    <= '0;
         commit_dest_q  <= '0;
         commit_value_q <= '0;
         proto_err_q    <= 1'b0;
         for (int i = 0; i < ENTRIES; i++) begin
            op_q[i]    <= '0;
            dest_q[i]  <= '0;
            value_q[i] <= '0;
         end
      end else begin
         busy_q         <= busy_d;
         ready_q        <= ready_d;
         head_q         <= head_d;
         tail_q         <= tail_d;
         count_q        <= count_d;
         commit_valid_q <= commit_valid_d;
         commit_idx_q   <= commit_idx_d;
         commit_op_q    <= commit_op_d;
         commit_dest_q  <= commit_dest_d;
         commit_value_q <= commit_value_d;
         proto_err_q    <= proto_err_d;
         op_q           <= op_d;
         dest_q         <= dest_d;
         value_q        <= value_d;
      end
   end

   assign busy_rb      = busy_q;
   assign head_idx     = head_q;
   assign rob_count    = count_q;
   assign commit_valid = commit_valid_q;
   assign commit_idx   = commit_idx_q;
   assign commit_op    = commit_op_q;
   assign commit_dest  = commit_dest_q;
   assign commit_value = commit_value_q;
   assign proto_err    = proto_err_q;

`ifdef ROB_OPERAND_READ_EN
   always_comb begin
      rd_ready0 = 1'b0;
      rd_value0 = '0;
      rd_ready1 = 1'b0;
      rd_value1 = '0;
      if (busy_q[rd_tag0]) begin
         if (cdb_valid && cdb_idx == rd_tag0) begin
            rd_ready0 = 1'b1;
            rd_value0 = cdb_value;
         end else if (ready_q[rd_tag0]) begin
            rd_ready0 = 1'b1;
            rd_value0 = value_q[rd_tag0];
         end
      end
      if (busy_q[rd_tag1]) begin
         if (cdb_valid && cdb_idx == rd_tag1) begin
            rd_ready1 = 1'b1;
            rd_value1 = cdb_value;
         end else if (ready_q[rd_tag1]) begin
            rd_ready1 = 1'b1;
            rd_value1 = value_q[rd_tag1];
         end
      end
   end
`endif

endmodule

// File: tb/tb_rob_commit.sv
// tb/tb_rob_commit.sv - directed bench for rob_commit with a queue-based program-order model.
module tb_rob_commit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        start = 1'b0;
   logic        issue_valid = 1'b0;
   logic [2:0]  issue_idx = '0;
   logic [2:0]  issue_op = '0;
   logic [4:0]  issue_dest = '0;
   logic        cdb_valid = 1'b0;
   logic [2:0]  cdb_idx = '0;
   logic [31:0] cdb_value = '0;
   logic        commit_stall = 1'b0;
   logic [7:0]  busy_rb;
   logic [2:0]  head_idx;
   logic [3:0]  rob_count;
   logic        commit_valid;
   logic [2:0]  commit_idx;
   logic [2:0]  commit_op;
   logic [4:0]  commit_dest;
   logic [31:0] commit_value;
   logic        proto_err;
`ifdef ROB_OPERAND_READ_EN
   logic [2:0]  rd_tag0 = '0;
   logic [2:0]  rd_tag1 = '0;
   logic        rd_ready0, rd_ready1;
   logic [31:0] rd_value0, rd_value1;
`endif

   rob_commit #(.DATA_W(32), .REG_W(5), .ENTRIES(8)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .issue_valid(issue_valid), .issue_idx(issue_idx), .issue_op(issue_op), .issue_dest(issue_dest),
      .cdb_valid(cdb_valid), .cdb_idx(cdb_idx), .cdb_value(cdb_value),
      .commit_stall(commit_stall),
      .busy_rb(busy_rb), .head_idx(head_idx), .rob_count(rob_count),
      .commit_valid(commit_valid), .commit_idx(commit_idx), .commit_op(commit_op),
      .commit_dest(commit_dest), .commit_value(commit_value),
`ifdef ROB_OPERAND_READ_EN
      .rd_tag0(rd_tag0), .rd_tag1(rd_tag1), .rd_ready0(rd_ready0), .rd_ready1(rd_ready1),
      .rd_value0(rd_value0), .rd_value1(rd_value1),
`endif
      .proto_err(proto_err)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // Model: the ROB is a program-order queue of tags; head/tail follow retired/issued counts.
   int          q[$];
   int unsigned issued, retired;
   bit          m_ready [8];
   logic [31:0] m_val   [8];
   logic [2:0]  m_op    [8];
   logic [4:0]  m_dest  [8];
   bit          m_cv, m_perr, m_cm;
   logic [2:0]  m_ci, m_cop;
   logic [4:0]  m_cdest;
   logic [31:0] m_cval;

   function automatic bit in_rob(input int idx);
      foreach (q[k]) if (q[k] == idx) return 1'b1;
      return 1'b0;
   endfunction

   task automatic mdl_reset();
      q.delete();
      issued = 0; retired = 0;
      m_cv = 0; m_ci = 0; m_cop = 0; m_cdest = 0; m_cval = 0; m_perr = 0;
      foreach (m_ready[k]) m_ready[k] = 0;
   endtask

   task automatic mdl_step();
      m_cm = (q.size() > 0) && m_ready[q[0]] && !commit_stall;
      m_cv = m_cm;
      if (m_cm) begin
         m_ci = 3'(q[0]); m_cop = m_op[q[0]]; m_cdest = m_dest[q[0]]; m_cval = m_val[q[0]];
      end
      if (cdb_valid && in_rob(int'(cdb_idx))) begin
         m_ready[cdb_idx] = 1; m_val[cdb_idx] = cdb_value;
      end
      if (issue_valid) begin
         if (int'(issue_idx) == int'(issued % 8) && !in_rob(int'(issue_idx))) begin
            q.push_back(int'(issue_idx));
            m_ready[issue_idx] = 0; m_op[issue_idx] = issue_op; m_dest[issue_idx] = issue_dest;
            issued++;
         end else m_perr = 1;
      end
      if (m_cm) begin
         void'(q.pop_front());
         retired++;
      end
   endtask

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) mdl_reset();
      else if (!start) mdl_reset();
      else mdl_step();
   end

   always @(posedge clk) begin
      logic [7:0] eb;
      #1;
      if (chk_en) begin
         eb = '0;
         foreach (q[k]) eb[q[k]] = 1'b1;
         chk("busy_rb", 64'(busy_rb), 64'(eb));
         chk("head_idx", 64'(head_idx), 64'(retired % 8));
         chk("rob_count", 64'(rob_count), 64'(q.size()));
         chk("commit_valid", 64'(commit_valid), 64'(m_cv));
         chk("commit_idx", 64'(commit_idx), 64'(m_ci));
         chk("commit_op", 64'(commit_op), 64'(m_cop));
         chk("commit_dest", 64'(commit_dest), 64'(m_cdest));
         chk("commit_value", 64'(commit_value), 64'(m_cval));
         chk("proto_err", 64'(proto_err), 64'(m_perr));
      end
   end

   task automatic drive(input bit iv, input logic [2:0] ii, input logic [2:0] io, input logic [4:0] id,
                        input bit cv, input logic [2:0] ci, input logic [31:0] cval, input bit st);
      issue_valid = iv; issue_idx = ii; issue_op = io; issue_dest = id;
      cdb_valid = cv; cdb_idx = ci; cdb_value = cval; commit_stall = st;
      @(negedge clk);
   endtask

   task automatic idle(input bit st);
      drive(0, 0, 0, 0, 0, 0, 0, st);
   endtask

   task automatic flush();
      start = 1'b0;
      idle(0);
      start = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      @(negedge clk);
      @(negedge clk);
      chk("rst_busy", 64'(busy_rb), 64'h0);
      chk("rst_count", 64'(rob_count), 64'h0);
      chk("rst_cv", 64'(commit_valid), 64'h0);
      chk("rst_perr", 64'(proto_err), 64'h0);
      rst_n = 1'b1; start = 1'b1; chk_en = 1'b1;

      drive(1, 0, 0, 3, 0, 0, 0, 0);
      drive(1, 1, 2, 4, 0, 0, 0, 0);
      drive(1, 2, 4, 5, 0, 0, 0, 0);
      chk("lit_busy07", 64'(busy_rb), 64'h07);
      chk("lit_count3", 64'(rob_count), 64'd3);
      chk("lit_head0", 64'(head_idx), 64'd0);
      chk("lit_nocommit", 64'(commit_valid), 64'd0);

      drive(0, 0, 0, 0, 1, 1, 32'h55, 0);
      drive(0, 0, 0, 0, 1, 0, 32'h11, 0);
      chk("lit_cdb_latency", 64'(commit_valid), 64'd0);
      idle(0);
      chk("lit_c0_valid", 64'(commit_valid), 64'd1);
      chk("lit_c0_dest", 64'(commit_dest), 64'd3);
      chk("lit_c0_value", 64'(commit_value), 64'h11);
      idle(0);
      chk("lit_c1_idx", 64'(commit_idx), 64'd1);
      chk("lit_c1_dest", 64'(commit_dest), 64'd4);
      chk("lit_c1_value", 64'(commit_value), 64'h55);
      idle(0);
      chk("lit_c2_held", 64'(commit_valid), 64'd0);
      chk("lit_busy04", 64'(busy_rb), 64'h04);
      drive(0, 0, 0, 0, 1, 2, 32'h22, 0);
      idle(0);
      chk("lit_c2_value", 64'(commit_value), 64'h22);

      flush();
      for (int i = 0; i < 8; i++) drive(1, 3'(i), 3'(i % 6), 5'(i + 8), 0, 0, 0, 1);
      for (int i = 0; i < 8; i++) drive(0, 0, 0, 0, 1, 3'(i), 32'h100 + i, 1);
      for (int i = 0; i < 3; i++) begin
         idle(1);
         chk("lit_full_busy", 64'(busy_rb), 64'hFF);
         chk("lit_stall_nocommit", 64'(commit_valid), 64'd0);
      end
      for (int i = 0; i < 8; i++) begin
         idle(0);
         chk("lit_drain_idx", 64'(commit_idx), 64'(i));
         chk("lit_drain_value", 64'(commit_value), 64'(32'h100 + i));
      end
      chk("lit_drained", 64'(busy_rb), 64'h00);

      for (int i = 0; i < 8; i++) drive(1, 3'(i), 3'd1, 5'(i), 0, 0, 0, 0);
      chk("lit_refull", 64'(rob_count), 64'd8);
      drive(0, 0, 0, 0, 1, 0, 32'hA0, 0);
      idle(0);
      chk("lit_wrap_freed", 64'(busy_rb), 64'hFE);
      drive(1, 0, 3, 7, 0, 0, 0, 0);
      chk("lit_wrap_busy", 64'(busy_rb), 64'hFF);
      chk("lit_wrap_perr", 64'(proto_err), 64'd0);
      drive(1, 3, 0, 1, 0, 0, 0, 0);
      chk("lit_ooo_perr", 64'(proto_err), 64'd1);
      chk("lit_ooo_count", 64'(rob_count), 64'd8);

      flush();
      chk("lit_flush_perr", 64'(proto_err), 64'd0);
      for (int i = 0; i < 5; i++) drive(1, 3'(i), 3'd0, 5'(i + 1), 0, 0, 0, 0);
      drive(0, 0, 0, 0, 1, 5, 32'h99, 0);
      chk("lit_cdb5_ignored", 64'(busy_rb), 64'h1F);
      drive(1, 5, 1, 6, 0, 0, 0, 0);
      for (int i = 0; i < 5; i++) drive(0, 0, 0, 0, 1, 3'(i), 32'(i + 1), 0);
      for (int i = 0; i < 3; i++) idle(0);
      chk("lit_idx5_held", 64'(busy_rb), 64'h20);
      chk("lit_idx5_nocommit", 64'(commit_valid), 64'd0);
      chk("lit_last_dest", 64'(commit_dest), 64'd5);

      drive(1, 6, 2, 10, 0, 0, 0, 0);
      drive(1, 7, 2, 11, 0, 0, 0, 0);
      drive(1, 0, 2, 12, 0, 0, 0, 0);
      chk("lit_four_busy", 64'(busy_rb), 64'hE1);
      flush();
      chk("lit_flush_busy", 64'(busy_rb), 64'h00);
      chk("lit_flush_head", 64'(head_idx), 64'd0);
      chk("lit_flush_count", 64'(rob_count), 64'd0);

      drive(1, 0, 4, 9, 0, 0, 0, 0);
      drive(1, 1, 4, 9, 1, 0, 32'h77, 0);
      idle(0);
      chk("lit_pre_rst_value", 64'(commit_value), 64'h77);
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      chk("lit_arst_busy", 64'(busy_rb), 64'h00);
      chk("lit_arst_count", 64'(rob_count), 64'd0);
      chk("lit_arst_value", 64'(commit_value), 64'd0);
      chk("lit_arst_dest", 64'(commit_dest), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(0);
      idle(0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
